serpent_key_sched: RTL and testbench
====================================

Name: serpent_key_sched

Overview:
- Serpent key-schedule engine. It expands a 128/192/256-bit user key into the 33 round keys K0..K32.
- It writes one round key per write strobe into the round-key memory: addresses 0..32, 128 bits each.
- It sits between the XTS key-load control and the round-key memory, and is the writer for that memory. The cipher core reads the memory only after o_done.
- Output uses the bitslice form: S-box applied, no IP.

Parameters:
- PHI, 32'h9E3779B9, golden-ratio constant for prekey generation.
- N_RKEYS, 33, number of round keys written.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  start expansion; sampled only in IDLE.
- i_key_len  in  2  key length: 00=128, 01=192, 10=256, 11 treated as 256.
- i_key  in  256  user key; [31:0] is the least-significant word. Sampled only on the accepted i_start.
- o_wr_en  out  1  round-key write strobe, one cycle per key.
- o_wr_addr  out  6  round-key index 0..32.
- o_wr_key  out  128  round key. Bits [31:0]=S-out word 0, [63:32]=word 1, [95:64]=word 2, [127:96]=word 3.
- o_busy  out  1  expansion in progress.
- o_done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset: i_rstn is asynchronous, active-low; clock is i_clk. All of the following reset to 0: o_wr_en, o_wr_addr, o_wr_key, o_busy, o_done, FSM state (IDLE), word counter, 8-word window.
- States: IDLE, GEN.
  - IDLE -> GEN on i_start.
  - GEN -> IDLE after prekey w131 is computed.
- Key padding: keys shorter than 256 bits get a single 1 appended directly above the MSB, then zeros.
  - 128-bit key: bit 128 = 1.
  - 192-bit key: bit 192 = 1.
  - Key bits above the selected length are ignored.
- Window load, on the accepted i_start (cycle T): w_-8..w_-1 = padded key words 0..7.
- Prekey generation, GEN cycles T+1..T+132:
  - One word per cycle, counter i = 0..131.
  - w_i = rotl11(w_{i-8} ^ w_{i-5} ^ w_{i-3} ^ w_{i-1} ^ PHI ^ i), with i zero-extended to 32 bits.
  - The window shifts by one word per cycle.
- Round-key formation, when i[1:0]==3 with k = i>>2:
  - Words w_{4k}..w_{4k+3} pass through S-box S[(35-k) mod 8].
  - Bitslice mapping: nibble j = {w_{4k+3}[j], w_{4k+2}[j], w_{4k+1}[j], w_{4k}[j]}; the output nibble bits go back to the same positions.
  - The result is registered into o_wr_key, with o_wr_addr=k.
- Write timing:
  - o_wr_en is high at cycle T+4k+5 for each k.
  - Exactly 33 strobes; the last (k=32) is at T+133.
  - o_wr_en is low in all other cycles. o_wr_key and o_wr_addr hold their value between strobes.
- Status outputs:
  - o_busy is high T+1..T+133.
  - o_done is high only at T+134.
  - i_start is ignored while o_busy=1.
  - i_start in the o_done cycle is accepted, so back-to-back expansions are allowed.
- Reset mid-expansion:
  - Everything returns to reset values and no further strobes occur.
  - Partially written memory contents are not valid.
  - o_done is not issued for an aborted run.
- Latency: start to o_done = 134 cycles.

Decomposition:
- Package serpent_pkg holds:
  - PHI.
  - The 8 S-box tables (16x4 each).
  - Key-length encodings.
  - The S-box select function (35-k) mod 8.
- Sub-module serpent_sbox_slice (combinational): inputs 3-bit box select and 4x32 words; output 4x32 words, 32 parallel 4-bit lookups. Shared later with the cipher round datapath.

Test Plan:
- Zero 256-bit key (i_key_len=10) -> internal w0 = 32'hBBCDCCF1. 33 strobes at T+5, T+9, ..., T+133 with addresses 0..32. o_wr_key values equal the golden C model. o_done at T+134.
- 128-bit key 000102030405060708090A0B0C0D0E0F (i_key_len=00), upper key bits randomized -> written keys equal the golden model with bit128 padding. Upper bits have no effect.
- 192-bit key and i_key_len=11 -> 192 matches the padded golden model. 11 gives results identical to 10.
- i_start pulsed at T+10 and T+60 during a run -> ignored. Exactly 33 writes; key contents unchanged.
- i_rstn asserted at T+50 -> all outputs 0 the same cycle, no further o_wr_en, no o_done. A new i_start then produces a full correct run.
- i_start held high continuously -> a new run starts in each o_done cycle. Successive runs are 134 cycles apart and the output sequence is identical each run.

Source files
------------

// File: rtl/serpent_pkg.sv
// Serpent key-schedule shared definitions.
// Constants, S-box tables and helper functions.
package serpent_pkg;

  localparam logic [31:0] PHI = 32'h9E3779B9;
  localparam int N_RKEYS = 33;
  localparam int N_WORDS = 4 * N_RKEYS;

  typedef enum logic [1:0] {
    KL_128  = 2'b00,
    KL_192  = 2'b01,
    KL_256  = 2'b10,
    KL_256X = 2'b11
  } key_len_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_e;

  // Entry x of box n lives in SBOX[n][4x+3:4x].
  localparam logic [7:0][63:0] SBOX = {
    64'h6539AC47B28E0FD1,
    64'h0A3DF19EB6485C27,
    64'h176D8E30C9A4B25F,
    64'hD7E9A4526B0C38F1,
    64'hE57A421D369C8BF0,
    64'h25B04E1DFAC39768,
    64'h43D68EB1A50972CF,
    64'hC90724DEB56A1F83
  };

  function automatic logic [3:0] sbox_lookup(
    input logic [2:0] sel,
    input logic [3:0] nib
  );
    logic [63:0] t;
    t = SBOX[sel];
    return t[{nib, 2'b00} +: 4];
  endfunction

  // Box (35-k) mod 8 only depends on k mod 8.
  function automatic logic [2:0] sbox_sel(
    input logic [2:0] k_lo
  );
    return 3'd3 - k_lo;
  endfunction

  function automatic logic [31:0] rotl11(
    input logic [31:0] x
  );
    return {x[20:0], x[31:21]};
  endfunction

  // Short keys get a single 1 just above their MSB.
  function automatic logic [255:0] pad_key(
    input logic [255:0] key,
    input key_len_e     len
  );
    logic [255:0] p;
    p = key;
    case (len)
      KL_128: begin
        p[255:128] = '0;
        p[128]     = 1'b1;
      end
      KL_192: begin
        p[255:192] = '0;
        p[192]     = 1'b1;
      end
      default: p = key;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/serpent_sbox_slice.sv
// Bitsliced Serpent S-box layer.
// 32 parallel 4-bit lookups across four words.
module serpent_sbox_slice
  import serpent_pkg::*;
(
  input  logic [2:0]       sel_i,
  input  logic [3:0][31:0] w_i,
  output logic [3:0][31:0] w_o
);

  for (genvar j = 0; j < 32; j++) begin : g_bit
    logic [3:0] s;
    assign s = sbox_lookup(
      sel_i,
      {w_i[3][j], w_i[2][j], w_i[1][j], w_i[0][j]}
    );
    assign w_o[0][j] = s[0];
    assign w_o[1][j] = s[1];
    assign w_o[2][j] = s[2];
    assign w_o[3][j] = s[3];
  end

endmodule

// File: rtl/serpent_key_sched.sv
// Serpent key-schedule engine.
// Writes round keys K0..K32 to the round-key memory.
module serpent_key_sched
  import serpent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [1:0]   i_key_len,
  input  logic [255:0] i_key,
  output logic         o_wr_en,
  output logic [5:0]   o_wr_addr,
  output logic [127:0] o_wr_key,
  output logic         o_busy,
  output logic         o_done
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0][31:0]  win_q, win_d;
  logic              wr_en_q, wr_en_d;
  logic [5:0]        addr_q, addr_d;
  logic [127:0]      key_q, key_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic [31:0]       w_new;
  logic [3:0][31:0]  slice_in;
  logic [3:0][31:0]  slice_out;

  // win_q[0] is w_{i-8}, win_q[7] is w_{i-1}.
  always_comb begin
    start_ok = (state_q == ST_IDLE) && i_start && !busy_q;
    w_new    = rotl11(win_q[0] ^ win_q[3] ^ win_q[5]
                      ^ win_q[7] ^ PHI ^ {24'h0, cnt_q});
    slice_in = {w_new, win_q[7], win_q[6], win_q[5]};
  end

  serpent_sbox_slice u_slice (
    .sel_i (sbox_sel(cnt_q[4:2])),
    .w_i   (slice_in),
    .w_o   (slice_out)
  );

  // Next-state, window shift and round-key capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    key_d   = key_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_GEN;
          cnt_d   = '0;
          win_d   = pad_key(i_key, key_len_e'(i_key_len));
        end
      end
      ST_GEN: begin
        win_d = {w_new, win_q[7:1]};
        cnt_d = cnt_q + 8'd1;
        if (cnt_q[1:0] == 2'd3) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q[7:2];
          key_d   = slice_out;
        end
        if (cnt_q == 8'(N_WORDS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Busy covers generation plus the trailing write cycle.
    busy_d = (state_d == ST_GEN) || wr_en_d;
    done_d = wr_en_q && (addr_q == 6'(N_RKEYS - 1));
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = addr_q;
  assign o_wr_key  = key_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_serpent_key_sched.sv
// Scoreboard bench for serpent_key_sched.
// Reference prekeys and S-boxes modelled in the bench.
module tb_serpent_key_sched;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   klen = 2'b00;
  logic [255:0] key = '0;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [127:0] wr_key;
  logic         busy;
  logic         done;

  serpent_key_sched dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_start   (start),
    .i_key_len (klen),
    .i_key     (key),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_key  (wr_key),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    int           c;
    logic [5:0]   addr;
    logic [127:0] k;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  int sb [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  logic [31:0]  mw [140];
  logic [127:0] exp_rk [33];

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic build_model(input logic [255:0] k,
                             input logic [1:0] len);
    logic [255:0] p;
    logic [31:0]  t;
    logic [3:0]   nib;
    logic [3:0]   o;
    int           box;
    p = k;
    if (len == 2'b00) begin
      p[255:128] = '0;
      p[128] = 1'b1;
    end else if (len == 2'b01) begin
      p[255:192] = '0;
      p[192] = 1'b1;
    end
    for (int j = 0; j < 8; j++) mw[j] = p[32*j +: 32];
    for (int i = 0; i < 132; i++) begin
      t = mw[i] ^ mw[i+3] ^ mw[i+5] ^ mw[i+7]
          ^ 32'h9E3779B9 ^ 32'(i);
      mw[i+8] = (t << 11) | (t >> 21);
    end
    for (int r = 0; r < 33; r++) begin
      box = (35 - r) % 8;
      for (int j = 0; j < 32; j++) begin
        nib = {mw[4*r+11][j], mw[4*r+10][j],
               mw[4*r+9][j], mw[4*r+8][j]};
        o = 4'(sb[box][nib]);
        for (int b = 0; b < 4; b++) exp_rk[r][32*b+j] = o[b];
      end
    end
  endtask

  task automatic push_run(input int base);
    wr_t e;
    for (int r = 0; r < 33; r++) begin
      e.c = base + 4*r + 5;
      e.addr = 6'(r);
      e.k = exp_rk[r];
      wq.push_back(e);
    end
    dq.push_back(base + 134);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_empty(input string nm);
    check({nm, "_wq_left"}, 128'(wq.size()), 128'd0);
    check({nm, "_dq_left"}, 128'(dq.size()), 128'd0);
  endtask

  task automatic run_one(input string nm,
                         input logic [255:0] k,
                         input logic [1:0] len,
                         input bit poke);
    int x;
    @(negedge clk);
    key = k;
    klen = len;
    build_model(k, len);
    start = 1'b1;
    x = cyc;
    push_run(x);
    @(negedge clk);
    start = 1'b0;
    key = ~k;
    klen = ~len;
    check({nm, "_busy_first"}, 128'(busy), 128'd1);
    if (poke) begin
      wait_until(x + 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(x + 60);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_until(x + 133);
    check({nm, "_busy_last"}, 128'(busy), 128'd1);
    wait_until(x + 134);
    check({nm, "_busy_off"}, 128'(busy), 128'd0);
    wait_until(x + 136);
    check_empty(nm);
  endtask

  // Monitor: pop and compare whenever the DUT writes or signals done.
  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (wr_en) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", 128'(wr_en), 128'd0);
      end else begin
        e = wq.pop_front();
        check("wr_cycle", 128'(cyc), 128'(e.c));
        check("wr_addr", 128'(wr_addr), 128'(e.addr));
        check("wr_key", wr_key, e.k);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        check("done_unexpected", 128'(done), 128'd0);
      end else begin
        dc = dq.pop_front();
        check("done_cycle", 128'(cyc), 128'(dc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] k;
    int x;

    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 128'(wr_en), 128'd0);
    check("rst_addr", 128'(wr_addr), 128'd0);
    check("rst_key", wr_key, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    build_model('0, 2'b10);
    check("model_w0", 128'(mw[8]), 128'(32'hBBCDCCF1));
    run_one("zero256", '0, 2'b10, 1'b0);

    k = {$urandom, $urandom, $urandom, $urandom,
         128'h000102030405060708090A0B0C0D0E0F};
    run_one("k128", k, 2'b00, 1'b0);
    k[255:128] = {$urandom, $urandom, $urandom, $urandom};
    run_one("k128b", k, 2'b00, 1'b0);

    k = {$urandom, $urandom,
         192'h0123456789ABCDEFFEDCBA987654321000112233445566};
    run_one("k192", k, 2'b01, 1'b0);

    k = 256'h00112233445566778899AABBCCDDEEFF_0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    run_one("k256x", k, 2'b11, 1'b0);
    run_one("k256", k, 2'b10, 1'b0);

    run_one("ignore", k, 2'b10, 1'b1);

    @(negedge clk);
    key = k;
    klen = 2'b01;
    build_model(k, 2'b01);
    start = 1'b1;
    x = cyc;
    push_run(x);
    @(negedge clk);
    start = 1'b0;
    wait_until(x + 50);
    rstn = 1'b0;
    #1;
    check("abort_wr_en", 128'(wr_en), 128'd0);
    check("abort_addr", 128'(wr_addr), 128'd0);
    check("abort_key", wr_key, 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    wq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (140) @(negedge clk);
    check_empty("abort");
    run_one("after_abort", k, 2'b01, 1'b0);

    @(negedge clk);
    k = 256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_13579BDF_2468ACE0_FFFFFFFF_80000001;
    key = k;
    klen = 2'b10;
    build_model(k, 2'b10);
    start = 1'b1;
    x = cyc;
    push_run(x);
    push_run(x + 134);
    push_run(x + 268);
    wait_until(x + 278);
    start = 1'b0;
    wait_until(x + 268 + 136);
    check_empty("held");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
